rr_grant_sched: RTL

Round-robin grant scheduler that shares one checked resource among `NUM_REQ` requesters using a req/gnt handshake. Requesters hold `req` until served. The scheduler answers with a registered one-hot `gnt` and keeps it until the owner signals `done`, drops `req`, or exceeds a hold limit. It is the sequencing block in front of datapaths whose protocol is checked by concurrent `req |-> ##1 gnt`-style assertions, so every rule below must be assertion-checkable cycle by cycle.

---
 rtl/rr_grant_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rr_grant_sched.sv
// Round-robin req/gnt scheduler: one registered one-hot owner at a time,
// released on done, req drop or hold limit, with a one-cycle bubble between owners.

module rr_grant_lane #(
    parameter int IDX = 0,
    parameter int PW  = 2
) (
    input  logic [PW-1:0] ptr,
    input  logic          req_bit,
    output logic          hi_req
);
    // Request sits at or above the rotating pointer, so it wins before wrapped ones.
    assign hi_req = req_bit && (PW'(IDX) >= ptr);
endmodule

module rr_grant_sched #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       gnt_vld,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       timeout
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_REL} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 gnt_vld_q, gnt_vld_d;
    logic [PW-1:0]        gnt_id_q, gnt_id_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_REQ-1:0]   hi_req;
    logic                 win_vld;
    logic                 use_hi;
    logic [PW-1:0]        win_id;
    logic                 owner_done;
    logic                 owner_req;
    logic                 hold_lim;
    logic                 release_now;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        rr_grant_lane #(.IDX(i), .PW(PW)) u_lane (
            .ptr     (ptr_q),
            .req_bit (req[i]),
            .hi_req  (hi_req[i])
        );
    end

    // Lowest set bit among requests at/above ptr; if none, lowest overall (wrap).
    always_comb begin
        win_vld = |req;
        use_hi  = |hi_req;
        win_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (use_hi ? hi_req[i] : req[i]) win_id = PW'(i);
        end
    end

    assign owner_done  = done[gnt_id_q];
    assign owner_req   = req[gnt_id_q];
    assign hold_lim    = (hold_cnt_q == HW'(MAX_HOLD));
    assign release_now = owner_done || !owner_req || hold_lim;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_vld_d  = gnt_vld_q;
        gnt_id_d   = gnt_id_q;
        timeout_d  = 1'b0;

        case (state_q)
            S_IDLE, S_REL: begin
                if (win_vld) begin
                    state_d    = S_OWN;
                    gnt_d      = NUM_REQ'(1) << win_id;
                    gnt_vld_d  = 1'b1;
                    gnt_id_d   = win_id;
                    hold_cnt_d = HW'(1);
                    ptr_d      = (win_id == PW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
                end else begin
                    state_d    = S_IDLE;
                    gnt_d      = '0;
                    gnt_vld_d  = 1'b0;
                    gnt_id_d   = '0;
                    hold_cnt_d = '0;
                end
            end
            S_OWN: begin
                if (release_now) begin
                    state_d    = S_REL;
                    gnt_d      = '0;
                    gnt_vld_d  = 1'b0;
                    gnt_id_d   = '0;
                    hold_cnt_d = '0;
                    // A concurrent done or req drop makes this an ordinary release.
                    timeout_d  = hold_lim && !owner_done && owner_req;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                gnt_d      = '0;
                gnt_vld_d  = 1'b0;
                gnt_id_d   = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_vld_q  <= 1'b0;
            gnt_id_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_vld_q  <= gnt_vld_d;
            gnt_id_q   <= gnt_id_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = gnt_vld_q;
    assign gnt_id  = gnt_id_q;
    assign timeout = timeout_q;

endmodule
